// File: rtl/adex_neuron.sv
// ============================================================================
// adex_neuron : adaptive exponential integrate-and-fire neuron with
//               refractory FSM, step enable and saturating spike counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module adex_neuron #(
   parameter int WIDTH         = 8,
   parameter int V_TH          = 128,
   parameter int V_PEAK        = 200,
   parameter int V_RESET       = 40,
   parameter int LEAK_SHIFT    = 3,
   parameter int DELTA_SHIFT   = 3,
   parameter int W_SHIFT       = 2,
   parameter int TAU_W_SHIFT   = 4,
   parameter int B_INC         = 16,
   parameter int REFRAC_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [WIDTH-1:0] current_i,
   output logic             spike_o,
   output logic [WIDTH-1:0] state_o,
   output logic [WIDTH-1:0] adapt_o,
   output logic             refractory_o,
   output logic             threshold_flag_o,
   output logic [7:0]       spike_count_o
);

   localparam int SW = WIDTH + 3;
   localparam int CW = $clog2(REFRAC_CYCLES + 1);

   localparam logic [WIDTH-1:0] C_MAX     = '1;
   localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] C_WIDTH   = WIDTH'(WIDTH);
   localparam logic [WIDTH-1:0] C_V_TH    = WIDTH'(V_TH);
   localparam logic [WIDTH-1:0] C_V_PEAK  = WIDTH'(V_PEAK);
   localparam logic [WIDTH-1:0] C_V_RESET = WIDTH'(V_RESET);
   localparam logic [WIDTH:0]   C_B_INC   = (WIDTH+1)'(B_INC);
   localparam logic [CW-1:0]    C_REFRAC  = CW'(REFRAC_CYCLES);
   localparam logic [CW-1:0]    C_RC_ONE  = CW'(1);

   typedef enum logic [0:0] {
      ST_INTEGRATE  = 1'b0,
      ST_REFRACTORY = 1'b1
   } state_e;

   state_e           fsm_q;
   logic [WIDTH-1:0] v_q;
   logic [WIDTH-1:0] w_q;
   logic [CW-1:0]    rcnt_q;
   logic             spike_q;
   logic [7:0]       count_q;

   logic [WIDTH-1:0]    v_over_d;
   logic [WIDTH-1:0]    exp_shift_d;
   logic [WIDTH-1:0]    exp_term_d;
   logic [SW-1:0]       v_sum_d;
   logic [WIDTH-1:0]    v_int_d;
   logic                fire_d;
   logic [WIDTH-1:0]    w_decay_d;
   logic [WIDTH:0]      w_bump_sum_d;
   logic [WIDTH-1:0]    w_bump_d;
   logic [7:0]          count_d;

   // Exponential term: a power of two indexed by how far v sits above V_TH.
   always_comb begin
      v_over_d    = v_q - C_V_TH;
      exp_shift_d = v_over_d >> DELTA_SHIFT;
      exp_term_d  = '0;
      if (v_q > C_V_TH) begin
         if (exp_shift_d >= C_WIDTH) exp_term_d = C_MAX;
         else                        exp_term_d = C_ONE << exp_shift_d;
      end
   end

   // Two's-complement sum with three headroom bits; the MSB is the sign.
   always_comb begin
      v_sum_d = {3'b000, v_q} + {3'b000, current_i} + {3'b000, exp_term_d}
              - {3'b000, (v_q >> LEAK_SHIFT)} - {3'b000, (w_q >> W_SHIFT)};
      if (v_sum_d[SW-1])                v_int_d = '0;
      else if (|v_sum_d[SW-2:WIDTH])    v_int_d = C_MAX;
      else                              v_int_d = v_sum_d[WIDTH-1:0];
      fire_d = (v_int_d >= C_V_PEAK);
   end

   always_comb begin
      w_decay_d    = w_q - (w_q >> TAU_W_SHIFT);
      w_bump_sum_d = {1'b0, w_decay_d} + C_B_INC;
      w_bump_d     = w_bump_sum_d[WIDTH] ? C_MAX : w_bump_sum_d[WIDTH-1:0];
      count_d      = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm_q   <= ST_INTEGRATE;
         v_q     <= '0;
         w_q     <= '0;
         rcnt_q  <= '0;
         spike_q <= 1'b0;
         count_q <= '0;
      end else begin
         spike_q <= 1'b0;
         if (en_i) begin
            case (fsm_q)
               ST_INTEGRATE: begin
                  if (fire_d) begin
                     v_q     <= C_V_RESET;
                     w_q     <= w_bump_d;
                     spike_q <= 1'b1;
                     count_q <= count_d;
                     rcnt_q  <= C_REFRAC;
                     fsm_q   <= ST_REFRACTORY;
                  end else begin
                     v_q <= v_int_d;
                     w_q <= w_decay_d;
                  end
               end
               ST_REFRACTORY: begin
                  v_q    <= C_V_RESET;
                  w_q    <= w_decay_d;
                  rcnt_q <= rcnt_q - C_RC_ONE;
                  if (rcnt_q == C_RC_ONE) fsm_q <= ST_INTEGRATE;
               end
               default: fsm_q <= ST_INTEGRATE;
            endcase
         end
      end
   end

   assign spike_o          = spike_q;
   assign state_o          = v_q;
   assign adapt_o          = w_q;
   assign refractory_o     = (fsm_q == ST_REFRACTORY);
   assign threshold_flag_o = (v_q >= C_V_TH);
   assign spike_count_o    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_adex_neuron.sv
// ============================================================================
// tb_adex_neuron : randomized scoreboard bench for adex_neuron against an
//                  integer reference model of the neuron dynamics.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_adex_neuron;

   localparam int V_TH    = 128;
   localparam int V_PEAK  = 200;
   localparam int V_RESET = 40;
   localparam int REFRAC  = 4;
   localparam int VMAX    = 255;

   typedef struct packed {
      logic       spike;
      logic [7:0] state;
      logic [7:0] adapt;
      logic       refr;
      logic       thr;
      logic [7:0] count;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en_i = 1'b1;
   logic [7:0] current_i = 8'd255;
   logic       spike_o;
   logic [7:0] state_o;
   logic [7:0] adapt_o;
   logic       refractory_o;
   logic       threshold_flag_o;
   logic [7:0] spike_count_o;

   int n_checks = 0;
   int n_errors = 0;
   exp_t sb_q[$];

   int m_v, m_w, m_refr, m_count;
   bit m_spike;

   adex_neuron dut (
      .clk              (clk),
      .rst              (rst),
      .en_i             (en_i),
      .current_i        (current_i),
      .spike_o          (spike_o),
      .state_o          (state_o),
      .adapt_o          (adapt_o),
      .refractory_o     (refractory_o),
      .threshold_flag_o (threshold_flag_o),
      .spike_count_o    (spike_count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int clamp(input int x, input int lo, input int hi);
      return (x < lo) ? lo : ((x > hi) ? hi : x);
   endfunction

   function automatic void model_reset();
      m_v = 0; m_w = 0; m_refr = 0; m_count = 0; m_spike = 0;
   endfunction

   // Neuron dynamics expressed directly as integer arithmetic.
   function automatic void model_step(input bit en, input int cur);
      int e, d, vs;
      m_spike = 0;
      if (!en) return;
      if (m_refr > 0) begin
         m_v = V_RESET;
         m_w = m_w - m_w / 16;
         m_refr = m_refr - 1;
      end else begin
         e = 0;
         if (m_v > V_TH) begin
            d = (m_v - V_TH) / 8;
            e = (d >= 8) ? VMAX : (1 << d);
         end
         vs = clamp(m_v + cur - m_v / 8 - m_w / 4 + e, 0, VMAX);
         if (vs >= V_PEAK) begin
            m_v = V_RESET;
            m_w = clamp(m_w - m_w / 16 + 16, 0, VMAX);
            m_spike = 1;
            if (m_count < 255) m_count++;
            m_refr = REFRAC;
         end else begin
            m_v = vs;
            m_w = m_w - m_w / 16;
         end
      end
   endfunction

   task automatic step(input bit en, input int cur);
      exp_t e;
      @(negedge clk);
      en_i = en;
      current_i = 8'(cur);
      model_step(en, cur);
      e.spike = m_spike;
      e.state = 8'(m_v);
      e.adapt = 8'(m_w);
      e.refr  = (m_refr > 0);
      e.thr   = (m_v >= V_TH);
      e.count = 8'(m_count);
      sb_q.push_back(e);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_spike"}, int'(spike_o), 0);
      chk({tag, "_state"}, int'(state_o), 0);
      chk({tag, "_adapt"}, int'(adapt_o), 0);
      chk({tag, "_refr"},  int'(refractory_o), 0);
      chk({tag, "_thr"},   int'(threshold_flag_o), 0);
      chk({tag, "_count"}, int'(spike_count_o), 0);
   endtask

   // Asynchronous reset: outputs must clear before any clock edge arrives.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      en_i = 1'b1;
      current_i = 8'd255;
      #1;
      check_zero(tag);
      @(negedge clk);
      check_zero({tag, "_held"});
      rst = 1'b0;
      en_i = 1'b0;
      model_reset();
   endtask

   // Monitor: every clock edge after a pushed step yields one output set.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("spike", int'(spike_o), int'(e.spike));
            chk("state", int'(state_o), int'(e.state));
            chk("adapt", int'(adapt_o), int'(e.adapt));
            chk("refractory", int'(refractory_o), int'(e.refr));
            chk("threshold_flag", int'(threshold_flag_o), int'(e.thr));
            chk("spike_count", int'(spike_count_o), int'(e.count));
         end
      end
   end

   initial begin
      int guard;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b0;
      en_i = 1'b0;

      // Subthreshold settle toward 64.
      for (int i = 0; i < 40; i++) step(1'b1, 8);
      @(posedge clk); #2;
      chk("settle_v64", int'(state_o), 64);

      // Immediate spike with enable gaps inside the refractory window.
      do_reset("reset_pre_spike");
      step(1'b1, 255);
      step(1'b1, 255);
      for (int i = 0; i < 3; i++) step(1'b0, 255);
      for (int i = 0; i < 4; i++) step(1'b1, 255);

      // Reset asserted while refractory.
      do_reset("reset_ready");
      step(1'b1, 255);
      step(1'b1, 255);
      @(posedge clk); #2;
      chk("pre_reset_refr", int'(refractory_o), 1);
      do_reset("reset_mid_refr");

      // Random inputs with random enable.
      for (int i = 0; i < 400; i++)
         step(($urandom_range(3, 0) != 0), int'($urandom_range(255, 0)));

      // Long saturation run.
      do_reset("reset_pre_sat");
      for (int i = 0; i < 1400; i++) step(1'b1, 255);
      @(posedge clk); #2;
      chk("sat_count", int'(spike_count_o), 255);

      guard = 0;
      while (sb_q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      if (sb_q.size() > 0) chk("scoreboard_drain", sb_q.size(), 0);
      #2;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/adex_neuron.md
# adex_neuron

Parametrised adaptive exponential integrate-and-fire (AdEx) neuron, the next generation of the team's single-neuron EIF core. Adds generic width, an adaptation current `w`, a refractory state machine, a per-step enable, and a saturating spike counter. Sits between the input-current source (switches or an upstream synapse block) and the spike/state outputs routed to the top-level pins. Each enabled cycle performs one update step.

## Interface
Parameters:
- WIDTH, 8, width of current, membrane `v` and adaptation `w` (unsigned)
- V_TH, 128, exponential onset threshold
- V_PEAK, 200, spike-detection level (V_TH < V_PEAK ≤ 2^WIDTH-1)
- V_RESET, 40, post-spike membrane value
- LEAK_SHIFT, 3, leak = v >> LEAK_SHIFT
- DELTA_SHIFT, 3, exponential slope divisor
- W_SHIFT, 2, adaptation coupling = w >> W_SHIFT
- TAU_W_SHIFT, 4, adaptation decay = w >> TAU_W_SHIFT
- B_INC, 16, spike-triggered adaptation increment
- REFRAC_CYCLES, 4, refractory length in enabled steps (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  step enable; no state change when low
- current  in  WIDTH  input current I
- spike  out  1  one-cycle pulse on each spike
- state  out  WIDTH  membrane potential v
- adapt  out  WIDTH  adaptation variable w
- refractory  out  1  high while in REFRACTORY
- threshold_flag  out  1  high when v ≥ V_TH
- spike_count  out  8  saturating spike counter (stops at 255)

## Operation
- Two states: INTEGRATE, REFRACTORY. Reset state INTEGRATE.
- exp_term: 0 if v ≤ V_TH; otherwise d = (v − V_TH) >> DELTA_SHIFT, exp_term = 1 << d, saturated to 2^WIDTH−1 (d ≥ WIDTH saturates).
- INTEGRATE step (en=1): v_sum = v + current − (v>>LEAK_SHIFT) − (w>>W_SHIFT) + exp_term, computed signed in WIDTH+3 bits, clamped to [0, 2^WIDTH−1].
  - v_sum ≥ V_PEAK: v ← V_RESET, spike ← 1, w ← sat(w − (w>>TAU_W_SHIFT) + B_INC), spike_count++ (saturating), go REFRACTORY, refractory counter ← REFRAC_CYCLES.
  - else v ← v_sum, w ← w − (w>>TAU_W_SHIFT).
- REFRACTORY step (en=1): v held at V_RESET, current ignored, w decays as above, counter decrements; when the counter reaches 0 on this step, return to INTEGRATE (exactly REFRAC_CYCLES enabled steps spent in REFRACTORY).
- w saturates at 2^WIDTH−1; never underflows (decay of 0 is 0).
- en=0: all registers hold, spike driven 0.
- threshold_flag is combinational from registered v.

## Timing
- Reset values: state=0, adapt=0, spike=0, refractory=0, threshold_flag=0, spike_count=0, FSM=INTEGRATE, refractory counter=0.
- Reset is asynchronous; assertion mid-refractory or mid-step returns to the reset values immediately; first update on the first enabled edge after deassertion.
- Latency: one cycle. v crossing detected at edge k ⇒ spike=1, state=V_RESET, refractory=1 visible after edge k.
- spike is high for exactly one clk cycle, even if en remains high.
- refractory drops after the edge that completes the REFRAC_CYCLES-th refractory step; the next enabled step integrates from V_RESET.
- Non-enabled cycles do not count toward the refractory period.

## Test plan
- Reset: hold rst=1 with current=255, en=1 → all outputs 0; release → first step updates v.
- Subthreshold settle: current=8, en=1 constant → v = 8, 15, 22, …, converges to 64 and holds; spike never asserts, threshold_flag=0.
- Immediate spike: from reset, current=255, en=1 → after first edge spike=1 (one cycle), state=40, adapt=16, refractory=1 for exactly 4 steps, spike_count=1; adapt decays to 15, 15, 15, 15 (16−1, then 15−0) during refractory.
- Enable gating: during refractory toggle en low for 3 cycles → state, adapt, counter frozen; refractory lasts 4 enabled steps total.
- Reset mid-operation: assert rst during refractory → refractory=0, state=0, adapt=0, spike_count=0 asynchronously (before next clk edge).
- Saturation: current=255 continuous for >300 steps → adapt saturates at ≤255 without wrap, spike_count stops at 255, state never exceeds 255 nor wraps negative.
